seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle ALU for unsigned WIDTH-bit operands: add, subtract, multiply, divide and integer square root. Arithmetic runs iteratively over a single shared datapath instead of unrolled combinational arrays. Operations are accepted through a valid/ready request handshake. Results are held under a valid/ready response handshake until the consumer takes them. The block sits between the operand/control logic and the result consumer as the team's general arithmetic unit.

## Interface
- WIDTH, 8: operand width in bits. Must be even and ≥ 4.
- in_clk  input  1  clock; all state changes on the rising edge.
- in_rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- out_ready  output  1  block can accept a request. High exactly in IDLE.
- in_op  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 SQRT; others illegal.
- in_a  input  WIDTH  operand A: addend, minuend, multiplicand, dividend or radicand.
- in_b  input  WIDTH  operand B: addend, subtrahend, multiplier or divisor; ignored for SQRT.
- out_valid  output  1  result valid. High exactly in DONE.
- in_ready  input  1  consumer accepts the result.
- out_result  output  2*WIDTH  packed result (see Operation).
- out_flag  output  1  status flag; meaning depends on opcode.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when in_valid & out_ready. Operands and opcode are registered at that edge; later changes on the inputs are ignored.
- IDLE → DONE directly for an illegal opcode, for DIV with in_b = 0, and for SQRT when compiled out.
- RUN iterates with a down-counter loaded on accept; RUN → DONE on the edge where the counter reaches its last step.
- DONE → IDLE on the edge where in_ready is high. A new request is never accepted in the same cycle a result is taken.
- ADD: out_result[WIDTH-1:0] = (a+b) mod 2^WIDTH; upper half 0; out_flag = carry out.
- SUB: out_result[WIDTH-1:0] = (a−b) mod 2^WIDTH; upper half 0; out_flag = borrow (a < b).
- MUL: shift-add, one partial product per cycle; out_result = full 2*WIDTH product; out_flag = 0.
- DIV: restoring division, one quotient bit per cycle, MSB first.
  - out_result = {remainder, quotient}; out_flag = 0.
  - b = 0: quotient all ones, remainder = a, out_flag = 1.
- SQRT: digit-by-digit, one root bit per cycle.
  - out_result[WIDTH/2-1:0] = floor(sqrt(a)); out_result[2*WIDTH-1:WIDTH] = a − root²; all other bits 0.
  - out_flag = 1 when the remainder ≠ 0 (a is not a perfect square).
- Illegal opcode: out_result = 0, out_flag = 1.
- out_result and out_flag are registered. They are stable for the whole DONE period, hold their last value in IDLE, and are don't-care in RUN.

## Timing
- Request accepted at edge T. out_valid rises at:
  - T+2 for ADD, SUB.
  - T+1+WIDTH for MUL, DIV.
  - T+1+WIDTH/2 for SQRT.
  - T+1 for illegal opcode, divide-by-zero and compiled-out SQRT.
- Backpressure: with in_ready low, DONE holds indefinitely with no change to outputs.
- Throughput: at most one operation in flight; no pipelining.
- Reset asserted (in_rst_n = 0), including mid-RUN or in DONE, takes effect immediately:
  - state = IDLE, out_valid = 0, out_result = 0, out_flag = 0, counter = 0.
  - out_ready = 1.
  - The in-flight operation is discarded; no partial result appears.
- First request can be accepted on the first rising edge after in_rst_n deasserts.

## Configuration
- SEQ_ALU_SQRT_EN defined: SQRT opcode 100 is implemented as specified; its root/remainder registers and step logic are present.
- SEQ_ALU_SQRT_EN undefined: the SQRT logic is not built. Opcode 100 is treated as illegal (result 0, out_flag 1, out_valid at T+1). All other opcodes are unchanged.

## Test plan
- WIDTH=8, ADD a=200 b=100 → out_result=0x002C, out_flag=1, out_valid at T+2; SUB a=5 b=7 → 0x00FE, out_flag=1.
- MUL a=255 b=255 → out_result=0xFE01, out_flag=0, out_valid at T+9; MUL a=0 b=77 → 0x0000.
- DIV a=200 b=7 → out_result=0x041C (remainder 4, quotient 28), out_flag=0 at T+9; DIV a=42 b=0 → 0x2AFF, out_flag=1 at T+1.
- SQRT (macro defined):
  - a=200 → 0x040E, out_flag=1 at T+5.
  - a=225 → 0x000F, out_flag=0.
  - Macro undefined, a=200 → 0x0000, out_flag=1 at T+1.
- Backpressure: DIV 200/7 with in_ready low for 3 cycles in DONE → out_valid and 0x041C stable throughout; IDLE follows the in_ready edge. in_valid asserted during RUN is ignored.
- Reset mid-operation: MUL 255×255 with in_rst_n pulsed low 3 cycles after accept:
  - out_valid = 0, out_result = 0, out_ready = 1 immediately.
  - A following ADD 1+1 → 0x0002 at T+2.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: iterative unsigned ADD/SUB/MUL/DIV/SQRT unit with valid/ready request and response.
// SQRT hardware is built only when SEQ_ALU_SQRT_EN is defined; otherwise opcode 100 is illegal.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic                 in_valid,
    output logic                 out_ready,
    input  logic [2:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 in_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_flag
);
    localparam int CW = $clog2(WIDTH);
    localparam int HW = WIDTH / 2;
    localparam int RW = HW + 2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SQRT = 3'b100;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_init;
    logic [2:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q;
    // {hi, lo}: MUL partial product / multiplier, DIV remainder / dividend-quotient, SQRT radicand in lo
    logic [2*WIDTH-1:0]   acc;
    logic                 run_ok;
    logic                 last;

    logic [WIDTH:0]       add_sum, sub_diff, mul_sum, div_sh;
    logic [2*WIDTH-1:0]   mul_nxt, div_nxt;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   run_res;
    logic                 run_flag;

`ifdef SEQ_ALU_SQRT_EN
    logic [RW-1:0]        sq_rem, sq_rem_n;
    logic [HW-1:0]        sq_root, sq_root_n;
    logic [RW+1:0]        sq_sh, sq_trial;
    logic                 sq_ge;
`endif

    assign out_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == '0);

    // Which accepted requests need the datapath, and how many RUN cycles they take
    always_comb begin
        run_ok   = 1'b0;
        cnt_init = '0;
        case (in_op)
            OP_ADD, OP_SUB: run_ok = 1'b1;
            OP_MUL: begin
                run_ok   = 1'b1;
                cnt_init = CW'(WIDTH - 1);
            end
            OP_DIV: begin
                run_ok   = (in_b != '0);
                cnt_init = CW'(WIDTH - 1);
            end
`ifdef SEQ_ALU_SQRT_EN
            OP_SQRT: begin
                run_ok   = 1'b1;
                cnt_init = CW'(HW - 1);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = run_ok ? RUN : DONE;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (in_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // One step of each iterative algorithm on the registered operands
    always_comb begin
        add_sum  = {1'b0, a_q} + {1'b0, b_q};
        sub_diff = {1'b0, a_q} - {1'b0, b_q};
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
        mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
        div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_rem  = div_ge ? WIDTH'(div_sh - {1'b0, b_q}) : div_sh[WIDTH-1:0];
        div_nxt  = {div_rem, acc[WIDTH-2:0], div_ge};
    end

`ifdef SEQ_ALU_SQRT_EN
    always_comb begin
        sq_sh     = {sq_rem, acc[WIDTH-1:WIDTH-2]};
        sq_trial  = (RW+2)'({sq_root, 2'b01});
        sq_ge     = (sq_sh >= sq_trial);
        sq_rem_n  = sq_ge ? RW'(sq_sh - sq_trial) : RW'(sq_sh);
        sq_root_n = {sq_root[HW-2:0], sq_ge};
    end
`endif

    always_comb begin
        run_res  = '0;
        run_flag = 1'b0;
        case (op_q)
            OP_ADD: begin
                run_res[WIDTH-1:0] = add_sum[WIDTH-1:0];
                run_flag           = add_sum[WIDTH];
            end
            OP_SUB: begin
                run_res[WIDTH-1:0] = sub_diff[WIDTH-1:0];
                run_flag           = sub_diff[WIDTH];
            end
            OP_MUL: run_res = mul_nxt;
            OP_DIV: run_res = div_nxt;
`ifdef SEQ_ALU_SQRT_EN
            OP_SQRT: begin
                run_res[HW-1:0]          = sq_root_n;
                run_res[2*WIDTH-1:WIDTH] = WIDTH'(sq_rem_n);
                run_flag                 = (sq_rem_n != '0);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            cnt        <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            out_result <= '0;
            out_flag   <= 1'b0;
`ifdef SEQ_ALU_SQRT_EN
            sq_rem     <= '0;
            sq_root    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= in_op;
                    a_q  <= in_a;
                    b_q  <= in_b;
                    cnt  <= cnt_init;
                    acc  <= {{WIDTH{1'b0}}, (in_op == OP_MUL) ? in_b : in_a};
`ifdef SEQ_ALU_SQRT_EN
                    sq_rem  <= '0;
                    sq_root <= '0;
`endif
                    // Short-circuit results: divide-by-zero and illegal opcodes
                    if (!run_ok) begin
                        out_result <= (in_op == OP_DIV) ? {in_a, {WIDTH{1'b1}}} : '0;
                        out_flag   <= 1'b1;
                    end
                end
                RUN: begin
                    if (!last) cnt <= cnt - CW'(1);
                    case (op_q)
                        OP_MUL: acc <= mul_nxt;
                        OP_DIV: acc <= div_nxt;
`ifdef SEQ_ALU_SQRT_EN
                        OP_SQRT: begin
                            acc     <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-3:0], 2'b00};
                            sq_rem  <= sq_rem_n;
                            sq_root <= sq_root_n;
                        end
`endif
                        default: ;
                    endcase
                    if (last) begin
                        out_result <= run_res;
                        out_flag   <= run_flag;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8; SQRT expectations follow SEQ_ALU_SQRT_EN.
module tb_seq_alu;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready;
    logic [2:0]     in_op;
    logic [W-1:0]   in_a, in_b;
    logic           out_ready, out_valid, out_flag;
    logic [2*W-1:0] out_result;

    int n_cmp = 0;
    int n_bad = 0;

    seq_alu #(.WIDTH(W)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_valid(in_valid), .out_ready(out_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .in_ready(in_ready), .out_result(out_result), .out_flag(out_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure edges to out_valid, check result; leave the DUT in DONE
    task automatic issue(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input logic [15:0] er, input logic ef);
        int n;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        chk({tag, " rdy"}, 32'(out_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = ~a; in_b = ~b; in_op = ~op;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " lat"}, 32'(n), 32'(lat));
        chk({tag, " res"}, 32'(out_result), 32'(er));
        chk({tag, " flg"}, 32'(out_flag), 32'(ef));
    endtask

    task automatic take(input string tag);
        @(negedge clk); in_ready = 1'b1;
        @(posedge clk); #1; in_ready = 1'b0;
        chk({tag, " idle"}, {30'd0, out_valid, out_ready}, 32'b01);
    endtask

    task automatic op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                      input logic [W-1:0] b, input int lat, input logic [15:0] er, input logic ef);
        issue(tag, o, a, b, lat, er, ef);
        take(tag);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0;
        #1;
        chk("rst vld", 32'(out_valid), 32'd0);
        chk("rst rdy", 32'(out_ready), 32'd1);
        chk("rst res", 32'(out_result), 32'd0);
        chk("rst flg", 32'(out_flag), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        op("add ovf",  3'b000, 8'd200, 8'd100, 2, 16'h002C, 1'b1);
        op("add zero", 3'b000, 8'd0,   8'd0,   2, 16'h0000, 1'b0);
        op("sub brw",  3'b001, 8'd5,   8'd7,   2, 16'h00FE, 1'b1);
        op("sub pos",  3'b001, 8'd7,   8'd5,   2, 16'h0002, 1'b0);
        op("mul max",  3'b010, 8'd255, 8'd255, 9, 16'hFE01, 1'b0);
        op("mul zero", 3'b010, 8'd0,   8'd77,  9, 16'h0000, 1'b0);
        op("mul 13x11",3'b010, 8'd13,  8'd11,  9, 16'h008F, 1'b0);
        op("div",      3'b011, 8'd200, 8'd7,   9, 16'h041C, 1'b0);
        op("div small",3'b011, 8'd7,   8'd200, 9, 16'h0700, 1'b0);
        op("div 0",    3'b011, 8'd42,  8'd0,   1, 16'h2AFF, 1'b1);
        op("illegal",  3'b111, 8'd9,   8'd9,   1, 16'h0000, 1'b1);
`ifdef SEQ_ALU_SQRT_EN
        op("sqrt 200", 3'b100, 8'd200, 8'd0,   5, 16'h040E, 1'b1);
        op("sqrt 225", 3'b100, 8'd225, 8'd3,   5, 16'h000F, 1'b0);
        op("sqrt 255", 3'b100, 8'd255, 8'd0,   5, 16'h1E0F, 1'b1);
`else
        op("sqrt off", 3'b100, 8'd200, 8'd0,   1, 16'h0000, 1'b1);
`endif

        // Backpressure: result held while in_ready low
        issue("bp", 3'b011, 8'd200, 8'd7, 9, 16'h041C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp hold", {15'd0, out_valid, out_result}, {15'd0, 1'b1, 16'h041C});
        end
        take("bp");

        // in_valid during RUN ignored; request held across the take edge waits a cycle
        @(negedge clk);
        in_op = 3'b010; in_a = 8'd255; in_b = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_op = 3'b000; in_a = 8'd3; in_b = 8'd4;
        repeat (3) @(posedge clk);
        #1 chk("run busy", 32'(out_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1 chk("run res", {15'd0, out_valid, out_result}, {15'd0, 1'b1, 16'hFE01});
        @(negedge clk); in_ready = 1'b1;
        @(posedge clk); #1; in_ready = 1'b0;
        chk("no same-cycle accept", {30'd0, out_valid, out_ready}, 32'b01);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("accept after take", 32'(out_ready), 32'd0);
        @(posedge clk); #1;
        chk("late add", {15'd0, out_valid, out_result}, {15'd0, 1'b1, 16'h0007});
        take("late add");

        // Reset in the middle of a MUL
        @(negedge clk);
        in_op = 3'b010; in_a = 8'd255; in_b = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst", {29'd0, out_valid, out_ready, out_flag}, 32'b010);
        chk("mid rst res", 32'(out_result), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        op("post rst add", 3'b000, 8'd1, 8'd1, 2, 16'h0002, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
